// File: rtl/sda_fir_pkg.sv
// sda_fir_pkg: shared types and constants for the sda8fir control sequencer.
// Optional build macro honoured by the sequencer: SDA_SAT_EN (output clamping).
package sda_fir_pkg;

    // Default datapath geometry: 8-bit samples, 18-bit DA accumulator, 16-bit output.
    localparam int SDA_BITS  = 8;
    localparam int SDA_ACC_W = 18;
    localparam int SDA_OUT_W = 16;

    // Clamp limits for the default geometry, expressed at accumulator width so
    // they compare directly against the signed accumulator result.
    localparam logic signed [SDA_ACC_W-1:0] SDA_SAT_MAX = SDA_ACC_W'((1 << (SDA_OUT_W-1)) - 1);
    localparam logic signed [SDA_ACC_W-1:0] SDA_SAT_MIN = -SDA_ACC_W'(1 << (SDA_OUT_W-1));

    // Sequencer states: wait for a sample, stream its bits, hand off the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } sda_state_e;

endpackage

// File: rtl/sda_fir_sequencer_serializer.sv
// sda_bit_serializer: holds the sample being streamed to the DA datapath,
// presents it LSB first and flags the final (sign) bit.
module sda_bit_serializer
    import sda_fir_pkg::*;
#(
    parameter int BITS = SDA_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift,
    input  logic [BITS-1:0] din,
    output logic            dbit,
    output logic            last
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    logic [BITS-1:0] shreg;
    logic [CW-1:0]   bit_cnt;

    // Load a fresh sample, or walk the current one towards bit 0 one bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= din;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign dbit = shreg[0];
    // The last serial bit is the two's-complement sign bit.
    assign last = (bit_cnt == CW'(BITS-1));

endmodule

// File: rtl/sda_fir_sequencer.sv
// sda_fir_sequencer: control sequencer for the bit-serial distributed-arithmetic
// 8-tap FIR datapath. One buffered input sample, BITS serial cycles plus one
// hand-off cycle per sample, and a valid/ready output register.
// Build macro SDA_SAT_EN: clamp captured results to the output range and pulse
// sat_flag on clamping; when undefined the result is truncated (wraps).
module sda_fir_sequencer
    import sda_fir_pkg::*;
#(
    parameter int BITS  = SDA_BITS,
    parameter int ACC_W = SDA_ACC_W,
    parameter int OUT_W = SDA_OUT_W
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    in_valid,
    input  logic signed [BITS-1:0]  in_data,
    output logic                    in_ready,
    output logic                    da_load,
    output logic                    da_bit,
    output logic                    da_acc_en,
    output logic                    da_msb,
    input  logic signed [ACC_W-1:0] da_result,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    sat_flag
);

    sda_state_e      state;
    logic            buf_valid;
    logic [BITS-1:0] buf_data;
    logic            accept;
    logic            cap_ok;
    logic            capture;
    logic            ser_bit;
    logic            ser_last;
    logic [OUT_W-1:0] cap_data;
    logic            cap_sat;

    // Input side: a single-entry buffer, free whenever it is empty.
    assign in_ready = ~buf_valid;
    assign accept   = in_valid & ~buf_valid;

    // The result register can take a new value if it is empty or being drained now.
    assign cap_ok  = ~out_valid | out_ready;
    assign capture = (state == DRAIN) & cap_ok;

    // A load either starts from IDLE or chains straight off a successful capture,
    // which is what gives the back-to-back rate of one sample per BITS+1 cycles.
    assign da_load   = buf_valid & ((state == IDLE) | capture);
    assign da_acc_en = (state == SHIFT);
    assign da_bit    = da_acc_en & ser_bit;
    assign da_msb    = da_acc_en & ser_last;

    sda_bit_serializer #(
        .BITS (BITS)
    ) u_ser (
        .clk   (clk),
        .rst   (Rst),
        .load  (da_load),
        .shift (da_acc_en),
        .din   (buf_data),
        .dbit  (ser_bit),
        .last  (ser_last)
    );

`ifdef SDA_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 << (OUT_W-1));

    // Clamp the accumulator into the signed output range, noting when it bites.
    always_comb begin
        cap_data = da_result[OUT_W-1:0];
        cap_sat  = 1'b0;
        if (da_result > SAT_MAX) begin
            cap_data = SAT_MAX[OUT_W-1:0];
            cap_sat  = 1'b1;
        end else if (da_result < SAT_MIN) begin
            cap_data = SAT_MIN[OUT_W-1:0];
            cap_sat  = 1'b1;
        end
    end
`else
    // Plain truncation: the upper accumulator bits are simply dropped.
    logic unused_res_hi;
    assign unused_res_hi = ^da_result[ACC_W-1:OUT_W];
    assign cap_data      = da_result[OUT_W-1:0];
    assign cap_sat       = 1'b0;
`endif

    // Sequencer state, input buffer and output register; the capture samples
    // da_result before the accompanying load clears the datapath accumulator.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            sat_flag <= capture & cap_sat;

            if (accept) begin
                buf_valid <= 1'b1;
                buf_data  <= in_data;
            end else if (da_load) begin
                buf_valid <= 1'b0;
            end

            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= cap_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE:    if (buf_valid) state <= SHIFT;
                SHIFT:   if (ser_last)  state <= DRAIN;
                DRAIN:   if (capture)   state <= buf_valid ? SHIFT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
